// File: rtl/gate_sweep_controller.sv
// gate_sweep_controller: drives every input vector onto a small combinational
// gate datapath. After each vector has had time to settle, it compares the
// datapath output with a reference reduction function. It reports the
// mismatch count, the first failing vector and an overall pass flag.
module gate_sweep_controller #(
  parameter int WIDTH  = 2,  // datapath inputs, 1..8
  parameter int SETTLE = 1,  // cycles between driving a vector and sampling, 1..15
  parameter int FUNC   = 0   // 0=NAND 1=AND 2=OR 3=NOR 4=XOR 5=XNOR, else NAND
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_r,
  output logic [WIDTH-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] fail_vec,
  output logic             fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] VEC_LAST    = '1;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  // The counter saturates at 2^WIDTH. A full sweep can never exceed that value,
  // but saturating keeps the counter from ever wrapping.
  localparam logic [WIDTH:0]   ERR_MAX     = {1'b1, {WIDTH{1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [WIDTH:0]   err_q, err_d;
  logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;
  logic             exp_bit;

  // Reference function over the vector currently driven onto the datapath
  always_comb begin
    exp_bit = ~(&vec_q);
    case (FUNC)
      1:       exp_bit = &vec_q;
      2:       exp_bit = |vec_q;
      3:       exp_bit = ~(|vec_q);
      4:       exp_bit = ^vec_q;
      5:       exp_bit = ~(^vec_q);
      default: exp_bit = ~(&vec_q);
    endcase
  end

  // State and result registers; reset discards any partial sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  // Next-state logic and result bookkeeping; everything holds unless updated
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_DRIVE;
          vec_d        = '0;
          settle_d     = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
        end
      end
      S_DRIVE: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dut_r != exp_bit) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        // The last vector ends the sweep, so vec_out never wraps back to zero
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = '0;
          state_d  = S_DRIVE;
        end
      end
      S_DONE: begin
        // err_q already includes the final CHECK here
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DRIVE) || (state_d == S_CHECK);
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule
